// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU behind a valid/ready handshake.
// Bitwise ops, ADD/SUB and divide-by-zero produce a result one cycle after accept.
// MUL (shift-add) and DIVU/REMU (restoring division) take DBITS iterations in BUSY.
// The result and its flags stay stable in DONE until the consumer takes them.
module seq_alu #(
    parameter int OPCODE_BIT_WIDTH = 4,
    parameter int DBITS            = 32,
    parameter int CNT_BITS         = $clog2(DBITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OPCODE_BIT_WIDTH-1:0] aluOp,
    input  logic [DBITS-1:0]            inA,
    input  logic [DBITS-1:0]            inB,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DBITS-1:0]            outAlu,
    output logic                        out_zero,
    output logic                        out_ovf,
    output logic                        out_dbz,
    output logic                        out_illegal
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

    state_t r_state, w_nextState;
    kind_t  r_kind, w_kind;

    logic [CNT_BITS-1:0]         r_cnt;
    logic [DBITS-1:0]            r_mcand, r_mplier, r_acc;
    logic [DBITS-1:0]            r_quo, r_div;
    logic [DBITS:0]              r_rem;
    logic [DBITS-1:0]            r_out;
    logic                        r_zero, r_ovf, r_dbz, r_ill;

    logic                        w_accept, w_last, w_hiOk, w_multi;
    logic [3:0]                  w_op;
    logic [OPCODE_BIT_WIDTH-1:0] w_hi;
    logic [DBITS-1:0]            w_sum, w_diff, w_res;
    logic                        w_ovf, w_dbz, w_ill;
    logic [DBITS-1:0]            w_mulAcc, w_quoNext, w_final;
    logic [DBITS:0]              w_shift, w_trial, w_remNext;
    logic                        w_fits;

    assign in_ready    = (r_state == IDLE) && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_last      = (r_cnt == CNT_BITS'(DBITS - 1));
    assign w_op        = aluOp[3:0];
    assign w_hi        = aluOp >> 4;
    assign w_hiOk      = (w_hi == '0);
    assign w_sum       = inA + inB;
    assign w_diff      = inA - inB;

    assign out_valid   = (r_state == DONE);
    assign outAlu      = r_out;
    assign out_zero    = r_zero;
    assign out_ovf     = r_ovf;
    assign out_dbz     = r_dbz;
    assign out_illegal = r_ill;

    // Decode the opcode and produce single-cycle results, or flag an op that needs iterating
    always_comb begin
        w_res   = '0;
        w_ovf   = 1'b0;
        w_dbz   = 1'b0;
        w_ill   = 1'b0;
        w_multi = 1'b0;
        w_kind  = K_MUL;
        if (!w_hiOk) begin
            w_ill = 1'b1;
        end else begin
            case (w_op)
                4'b0000: begin
                    w_res = w_sum;
                    w_ovf = (inA[DBITS-1] == inB[DBITS-1]) && (w_sum[DBITS-1] != inA[DBITS-1]);
                end
                4'b0001: begin
                    w_res = w_diff;
                    w_ovf = (inA[DBITS-1] != inB[DBITS-1]) && (w_diff[DBITS-1] != inA[DBITS-1]);
                end
                4'b0100: w_res = inA & inB;
                4'b0101: w_res = inA | inB;
                4'b0110: w_res = inA ^ inB;
                4'b1100: w_res = ~(inA & inB);
                4'b1101: w_res = ~(inA | inB);
                4'b1110: w_res = ~(inA ^ inB);
                4'b1000: begin
                    w_multi = 1'b1;
                    w_kind  = K_MUL;
                end
                4'b1001: begin
                    if (inB == '0) begin
                        w_res = '1;
                        w_dbz = 1'b1;
                    end else begin
                        w_multi = 1'b1;
                        w_kind  = K_DIV;
                    end
                end
                4'b1010: begin
                    if (inB == '0) begin
                        w_res = inA;
                        w_dbz = 1'b1;
                    end else begin
                        w_multi = 1'b1;
                        w_kind  = K_REM;
                    end
                end
                default: w_ill = 1'b1;
            endcase
        end
    end

    // One shift-add multiply step and one restoring-division step, plus the final result pick
    always_comb begin
        w_mulAcc  = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_shift   = {r_rem[DBITS-1:0], r_quo[DBITS-1]};
        w_trial   = w_shift - {1'b0, r_div};
        w_fits    = ~w_trial[DBITS];
        w_remNext = w_fits ? w_trial : w_shift;
        w_quoNext = {r_quo[DBITS-2:0], w_fits};
        case (r_kind)
            K_DIV:   w_final = w_quoNext;
            K_REM:   w_final = w_remNext[DBITS-1:0];
            default: w_final = w_mulAcc;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state logic: IDLE -> BUSY/DONE on accept, BUSY -> DONE on last step, DONE -> IDLE on take
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = w_multi ? BUSY : DONE;
            BUSY:    if (w_last) w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: latch operands or a one-cycle result on accept, iterate in BUSY, hold in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kind   <= K_MUL;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_out    <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            r_kind   <= w_kind;
                            r_cnt    <= '0;
                            r_mcand  <= inA;
                            r_mplier <= inB;
                            r_acc    <= '0;
                            r_quo    <= inA;
                            r_div    <= inB;
                            r_rem    <= '0;
                        end else begin
                            r_out  <= w_res;
                            r_zero <= (w_res == '0);
                            r_ovf  <= w_ovf;
                            r_dbz  <= w_dbz;
                            r_ill  <= w_ill;
                        end
                    end
                end
                BUSY: begin
                    r_cnt    <= r_cnt + CNT_BITS'(1);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_acc    <= w_mulAcc;
                    r_quo    <= w_quoNext;
                    r_rem    <= w_remNext;
                    if (w_last) begin
                        r_out  <= w_final;
                        r_zero <= (w_final == '0);
                        r_ovf  <= 1'b0;
                        r_dbz  <= 1'b0;
                        r_ill  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
